// File: rtl/psram_user_model.sv
// BRAM-backed stand-in for the PSRAM controller user port: one command per TCMD clocks,
// four 64-bit beats per burst, reads return RD_LAT clocks after accept; extra cmd_en are dropped and counted.
module psram_user_model #(
  parameter int ADDR_W       = 8,
  parameter int CALIB_CYCLES = 64,
  parameter int RD_LAT       = 6,
  parameter int TCMD         = 14
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_en,
  input  logic        cmd,
  input  logic [20:0] addr,
  input  logic [63:0] wr_data,
  input  logic [7:0]  data_mask,
  output logic [63:0] rd_data,
  output logic        rd_data_valid,
  output logic        init_calib,
  output logic        cmd_drop,
  output logic [7:0]  drop_count
);

  localparam int CW = $clog2(((CALIB_CYCLES > TCMD) ? CALIB_CYCLES : TCMD) + 1);
  localparam int DEPTH = 1 << (ADDR_W + 2);

  localparam logic [1:0] CALIB = 2'd0;
  localparam logic [1:0] IDLE  = 2'd1;
  localparam logic [1:0] BUSY  = 2'd2;

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic              cmd_q;
  logic [ADDR_W-1:0] addr_q;

  logic [63:0]       mem [0:DEPTH-1];
  logic [63:0]       mem_q;

  logic              accept;
  logic              drop;
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W+1:0] waddr;
  logic [ADDR_W+1:0] raddr;
  logic [7:0]        be;
  logic [CW-1:0]     rd_off;
  logic              unused_bits;

  assign accept = cmd_en && (state == IDLE);
  assign drop   = cmd_en && (state != IDLE);

  // Beat 0 is taken on the accepting edge itself, so its address comes straight from the port.
  assign wr_en = (accept && cmd) || ((state == BUSY) && cmd_q && (cnt <= CW'(3)));
  assign waddr = accept ? {addr[ADDR_W-1:0], 2'b00} : {addr_q, cnt[1:0]};

  assign rd_en  = (state == BUSY) && !cmd_q && (cnt >= CW'(RD_LAT)) && (cnt <= CW'(RD_LAT + 3));
  assign rd_off = cnt - CW'(RD_LAT);
  assign raddr  = {addr_q, rd_off[1:0]};

  // Mask bits [3:0] belong to chip0 (even bytes), [7:4] to chip1 (odd bytes).
  assign be = {~data_mask[7], ~data_mask[3], ~data_mask[6], ~data_mask[2],
               ~data_mask[5], ~data_mask[1], ~data_mask[4], ~data_mask[0]};

  assign rd_data = rd_data_valid ? mem_q : 64'd0;

  assign unused_bits = ^{addr[20:ADDR_W], rd_off[CW-1:2]};

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 8; b++) begin
        if (be[b]) mem[waddr][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
    if (rd_en) mem_q <= mem[raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= CALIB;
      cnt           <= '0;
      cmd_q         <= 1'b0;
      addr_q        <= '0;
      rd_data_valid <= 1'b0;
      init_calib    <= 1'b0;
      cmd_drop      <= 1'b0;
      drop_count    <= 8'd0;
    end else begin
      rd_data_valid <= rd_en;
      if (drop) begin
        cmd_drop <= 1'b1;
        if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
      case (state)
        CALIB: begin
          if (cnt == CW'(CALIB_CYCLES - 1)) begin
            init_calib <= 1'b1;
            state      <= IDLE;
            cnt        <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        IDLE: begin
          if (cmd_en) begin
            state  <= BUSY;
            cnt    <= CW'(1);
            cmd_q  <= cmd;
            addr_q <= addr[ADDR_W-1:0];
          end
        end
        BUSY: begin
          if (cnt == CW'(TCMD - 1)) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= CALIB;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psram_user_model.sv
// Directed bench for psram_user_model: calibration, masked writes, drops, aliasing, burst timing, reset mid-read.
module tb_psram_user_model;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_en = 1'b0;
  logic        cmd = 1'b0;
  logic [20:0] addr = '0;
  logic [63:0] wr_data = '0;
  logic [7:0]  data_mask = 8'hFF;
  logic [63:0] rd_data;
  logic        rd_data_valid;
  logic        init_calib;
  logic        cmd_drop;
  logic [7:0]  drop_count;

  int checks = 0;
  int failures = 0;

  logic        vld_s [1:13];
  logic [63:0] dat_s [1:13];

  always #5 clk = ~clk;

  psram_user_model dut (
    .clk(clk), .rst_n(rst_n), .cmd_en(cmd_en), .cmd(cmd), .addr(addr),
    .wr_data(wr_data), .data_mask(data_mask), .rd_data(rd_data),
    .rd_data_valid(rd_data_valid), .init_calib(init_calib),
    .cmd_drop(cmd_drop), .drop_count(drop_count)
  );

  // Called at a negedge with the model idle; returns at the negedge after edge 'last' of the burst.
  task drive_write(input logic [20:0] a,
                   input logic [63:0] d0, input logic [63:0] d1,
                   input logic [63:0] d2, input logic [63:0] d3,
                   input logic [7:0] m0, input logic [7:0] m1,
                   input logic [7:0] m2, input logic [7:0] m3,
                   input int last);
    cmd_en = 1'b1; cmd = 1'b1; addr = a; wr_data = d0; data_mask = m0;
    @(negedge clk); cmd_en = 1'b0; wr_data = d1; data_mask = m1;
    @(negedge clk); wr_data = d2; data_mask = m2;
    @(negedge clk); wr_data = d3; data_mask = m3;
    @(negedge clk); wr_data = '0; data_mask = 8'hFF;
    for (int k = 4; k <= last; k++) @(negedge clk);
  endtask

  // cmd_en is high for pre dropped edges, the accepting edge, then post more edges.
  // Samples are taken at the negedge after each post-accept edge 1..13.
  task drive_read(input logic [20:0] a, input int pre, input int post);
    cmd_en = 1'b1; cmd = 1'b0; addr = a;
    for (int i = 0; i < pre; i++) @(negedge clk);
    @(negedge clk);
    if (post == 0) cmd_en = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      vld_s[k] = rd_data_valid;
      dat_s[k] = rd_data;
      if (k == post) cmd_en = 1'b0;
    end
  endtask

  task test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (rd_data_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rd_data_valid); end
    checks++; if (rd_data !== 64'd0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    checks++; if (init_calib !== 1'b0) begin failures++; $display("FAIL reset_init_calib got=%b exp=0", init_calib); end
    checks++; if (cmd_drop !== 1'b0) begin failures++; $display("FAIL reset_cmd_drop got=%b exp=0", cmd_drop); end
    checks++; if (drop_count !== 8'd0) begin failures++; $display("FAIL reset_drop_count got=%0d exp=0", drop_count); end
    rst_n = 1'b1;
    for (int n = 1; n <= 64; n++) begin
      @(negedge clk);
      if (n == 9) begin cmd_en = 1'b1; cmd = 1'b0; addr = 21'd1; end
      if (n == 10) cmd_en = 1'b0;
      if (n == 63) begin
        checks++; if (init_calib !== 1'b0) begin failures++; $display("FAIL calib_early got=%b exp=0", init_calib); end
      end
      if (n == 64) begin
        checks++; if (init_calib !== 1'b1) begin failures++; $display("FAIL calib_rise got=%b exp=1", init_calib); end
      end
    end
    checks++; if (cmd_drop !== 1'b1) begin failures++; $display("FAIL calib_drop got=%b exp=1", cmd_drop); end
    checks++; if (drop_count !== 8'd1) begin failures++; $display("FAIL calib_drop_count got=%0d exp=1", drop_count); end
  endtask

  task test_masked_write;
    logic [63:0] exp_d [0:3];
    exp_d[0] = 64'h11223344_DEADBEEF;
    exp_d[1] = 64'hAAAA_AAAA_AAAA_AAAA;
    exp_d[2] = 64'hBBBB_BBBB_BBBB_BBBB;
    exp_d[3] = 64'hCCCC_CCCC_CCCC_CCCC;
    drive_write(21'd5, 64'h11223344_55667788, exp_d[1], exp_d[2], exp_d[3],
                8'h00, 8'h00, 8'h00, 8'h00, 13);
    drive_write(21'd5, 64'h00000000_DEADBEEF, 64'h1, 64'h2, 64'h3,
                8'hCC, 8'hFF, 8'hFF, 8'hFF, 13);
    drive_read(21'd5, 0, 0);
    for (int k = 1; k <= 13; k++) begin
      checks++;
      if (vld_s[k] !== ((k >= 6) && (k <= 9))) begin
        failures++; $display("FAIL mask_valid k=%0d got=%b exp=%b", k, vld_s[k], (k >= 6) && (k <= 9));
      end
    end
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (dat_s[6+b] !== exp_d[b]) begin
        failures++; $display("FAIL mask_beat%0d got=%h exp=%h", b, dat_s[6+b], exp_d[b]);
      end
    end
  endtask

  task test_cmd_hold;
    int nv;
    nv = 0;
    drive_read(21'd5, 0, 1);
    for (int k = 1; k <= 13; k++) if (vld_s[k] === 1'b1) nv++;
    checks++; if (nv != 4) begin failures++; $display("FAIL hold_beats got=%0d exp=4", nv); end
    checks++; if (vld_s[6] !== 1'b1 || vld_s[5] !== 1'b0) begin failures++; $display("FAIL hold_first got=%b%b exp=10", vld_s[6], vld_s[5]); end
    checks++; if (dat_s[6] !== 64'h11223344_DEADBEEF) begin failures++; $display("FAIL hold_data got=%h exp=11223344deadbeef", dat_s[6]); end
    checks++; if (cmd_drop !== 1'b1) begin failures++; $display("FAIL hold_cmd_drop got=%b exp=1", cmd_drop); end
    checks++; if (drop_count !== 8'd2) begin failures++; $display("FAIL hold_drop_count got=%0d exp=2", drop_count); end
  endtask

  task test_alias;
    drive_write(21'd3, 64'hA0, 64'hA1, 64'hA2, 64'hA3, 8'h00, 8'h00, 8'h00, 8'h00, 13);
    drive_write(21'd259, 64'hB0, 64'hB1, 64'hB2, 64'hB3, 8'h00, 8'h00, 8'h00, 8'h00, 13);
    drive_read(21'd3, 0, 0);
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (dat_s[6+b] !== (64'hB0 + 64'(b))) begin
        failures++; $display("FAIL alias_beat%0d got=%h exp=%h", b, dat_s[6+b], 64'hB0 + 64'(b));
      end
    end
  endtask

  task test_back_to_back;
    logic [63:0] exp_d;
    // Write ends one edge early so the read's first cmd_en lands on the final busy edge.
    drive_write(21'd9, 64'd1, 64'd2, 64'd3, 64'd4, 8'h00, 8'h00, 8'h00, 8'h00, 12);
    drive_read(21'd9, 1, 0);
    checks++; if (drop_count !== 8'd3) begin failures++; $display("FAIL b2b_drop_count got=%0d exp=3", drop_count); end
    for (int k = 1; k <= 13; k++) begin
      exp_d = ((k >= 6) && (k <= 9)) ? 64'(k - 5) : 64'd0;
      checks++;
      if (vld_s[k] !== ((k >= 6) && (k <= 9)) || dat_s[k] !== exp_d) begin
        failures++; $display("FAIL b2b_k%0d got=%b/%h exp=%b/%h", k, vld_s[k], dat_s[k], (k >= 6) && (k <= 9), exp_d);
      end
    end
  endtask

  task test_reset_mid_read;
    cmd_en = 1'b1; cmd = 1'b0; addr = 21'd9;
    @(negedge clk); cmd_en = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (rd_data_valid !== 1'b1 || rd_data !== 64'd3) begin failures++; $display("FAIL mid_beat2 got=%b/%h exp=1/3", rd_data_valid, rd_data); end
    rst_n = 1'b0;
    #1;
    checks++; if (rd_data_valid !== 1'b0 || rd_data !== 64'd0) begin failures++; $display("FAIL mid_async got=%b/%h exp=0/0", rd_data_valid, rd_data); end
    checks++; if (init_calib !== 1'b0) begin failures++; $display("FAIL mid_calib got=%b exp=0", init_calib); end
    checks++; if (drop_count !== 8'd0 || cmd_drop !== 1'b0) begin failures++; $display("FAIL mid_drop got=%b/%0d exp=0/0", cmd_drop, drop_count); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 64; n++) begin
      @(negedge clk);
      if (n == 63) begin
        checks++; if (init_calib !== 1'b0) begin failures++; $display("FAIL recal_early got=%b exp=0", init_calib); end
      end
    end
    checks++; if (init_calib !== 1'b1) begin failures++; $display("FAIL recal_rise got=%b exp=1", init_calib); end
    drive_read(21'd9, 0, 0);
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (vld_s[6+b] !== 1'b1 || dat_s[6+b] !== 64'(b + 1)) begin
        failures++; $display("FAIL recal_beat%0d got=%b/%h exp=1/%h", b, vld_s[6+b], dat_s[6+b], 64'(b + 1));
      end
    end
  endtask

  initial begin
    test_reset;
    test_masked_write;
    test_cmd_hold;
    test_alias;
    test_back_to_back;
    test_reset_mid_read;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
